fuzz_vector_harness: RTL and testbench
======================================

Name: fuzz_vector_harness

Overview:
Synthesizable stimulus/response harness for differential fuzzing of generated designs.
- Drives a DUT input bus of configurable width with a sequence of NUM_VEC vectors from a selectable generator.
- After a programmable settle time, captures the DUT output bus of configurable width into a 32-bit MISR signature.
- Sits beside the DUT inside simulation/synthesis wrappers, so runs on different simulators and netlists compare by one signature instead of per-cycle dumps.

Parameters:
- IN_W, 256: DUT input bus width (>=1).
- OUT_W, 242: DUT output bus width (>=1).
- NUM_VEC, 21: vectors per run (>=1).
- SETTLE, 0: idle cycles between applying a vector and capturing (>=0).
- SIG_INIT, 32'hFFFFFFFF: MISR value loaded at start.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a run; honoured only in IDLE or DONE.
- mode, input, 2: generator select, latched at start.
- seed, input, 32: LFSR seed, latched at start.
- dut_in, output, IN_W: stimulus to DUT.
- dut_out, input, OUT_W: DUT response.
- busy, output, 1: run in progress.
- done, output, 1: run complete; held until next start or reset.
- cap_valid, output, 1: high during the cycle dut_out is sampled.
- vec_idx, output, max(1,$clog2(NUM_VEC)): index of the vector currently applied.
- signature, output, 32: MISR value.

Behaviour:
- Reset (async, rst=1): state IDLE; dut_in=0, busy=0, done=0, cap_valid=0, vec_idx=0, signature=0, LFSR=0.
- States: IDLE, SETTLE, CAPTURE, DONE. busy=1 in SETTLE/CAPTURE. done=1 only in DONE. cap_valid=1 only in CAPTURE (decoded from the state register).
- Start edge (start=1 in IDLE/DONE):
  - latch mode and seed; LFSR <= (seed==0 ? 32'h1 : seed); signature <= SIG_INIT; vec_idx <= 0; done <= 0.
  - dut_in <= vector 0.
  - state <= SETTLE if SETTLE>0, else CAPTURE.
- SETTLE: counts SETTLE cycles, then goes to CAPTURE. dut_in is stable throughout.
- CAPTURE edge:
  - signature <= step(signature) ^ fold(dut_out).
  - If vec_idx==NUM_VEC-1: state <= DONE.
  - Else: vec_idx++, dut_in <= next vector, state <= SETTLE/CAPTURE as above.
- Timing: each vector occupies SETTLE+1 cycles. done rises NUM_VEC*(SETTLE+1) edges after the start edge. Signature is final when done=1.
- start while busy is ignored. start in DONE restarts cleanly, same as from IDLE.
- step(s) = (s<<1) ^ (s[31] ? 32'h04C11DB7 : 0), 32-bit, carries discarded.
- fold(x): zero-pad x to a multiple of 32 bits, XOR all 32-bit chunks together.
- Generators (vector i):
  - mode 0, LFSR: LFSR advances CHUNKS=ceil(IN_W/32) steps per vector using step(). Chunk k (k=0 at LSB) = state after k+1 steps. Concatenate chunks, truncate to IN_W.
  - mode 1, walking one: dut_in = 1 << (i mod IN_W).
  - mode 2, alternation: dut_in = all zeros for even i, all ones for odd i.
  - mode 3, LFSR with vector 0 forced to all zeros: LFSR does not advance for vector 0; vector 1 equals mode 0's vector 0.
- Reset mid-run: immediate return to reset values; no partial signature retained.
- A stuck-at-zero LFSR is impossible by construction (seed 0 is substituted with 32'h1).

Test Plan:
All scenarios use IN_W=8, OUT_W=8, NUM_VEC=4, SETTLE=0, with dut_out looped back to dut_in, unless stated otherwise.
- Reset check: assert rst mid-CAPTURE -> all outputs 0 in the same cycle; after release, state IDLE; next start gives the same signature as a clean run.
- Mode 1 -> dut_in sequence 01,02,04,08 on consecutive cycles; cap_valid high for 4 cycles; signature after first capture = 32'hFB3EE248; done rises 4 edges after start.
- Mode 2 -> dut_in 00,FF,00,FF. Mode 0 with seed 0 -> dut_in 02,04,08,10 (identical to seed 1). Mode 3 with seed 1 -> 00,02,04,08.
- SETTLE=3 -> each vector held 4 cycles; cap_valid only on the 4th; done at edge 16.
- Pulse start at every edge during a run -> ignored; after done, start -> signature re-initialised to SIG_INIT and sequence repeats identically.
- Defaults (IN_W=256, OUT_W=242, NUM_VEC=21), mode 0, seed 32'hDEADBEEF -> signature matches the bench reference model; 8 LFSR chunks per vector; bits above OUT_W are zero-padded in fold.

Source files
------------

// File: rtl/fuzz_vector_harness.sv
// Stimulus/response harness: drives NUM_VEC generated vectors into a DUT
// and compresses the sampled DUT responses into a 32-bit MISR signature.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   start, mode, seed begin a run (IDLE/DONE only); generator select, LFSR seed
//   dut_in / dut_out  stimulus to the DUT / response from the DUT
//   busy, done        run in progress / run complete (held)
//   cap_valid         dut_out is being sampled this cycle
//   vec_idx           index of the vector currently applied
//   signature         MISR value, final once done is high
module fuzz_vector_harness #(
    parameter int          IN_W     = 256,
    parameter int          OUT_W    = 242,
    parameter int          NUM_VEC  = 21,
    parameter int          SETTLE   = 0,
    parameter logic [31:0] SIG_INIT = 32'hFFFF_FFFF,
    localparam int         VW       = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [31:0]      seed,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             cap_valid,
    output logic [VW-1:0]    vec_idx,
    output logic [31:0]      signature
);

    localparam int IN_CH  = (IN_W + 31) / 32;
    localparam int OUT_CH = (OUT_W + 31) / 32;
    localparam int CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    // State entered whenever a new vector is applied.
    localparam state_e ST_APPLY = (SETTLE > 0) ? ST_SETTLE : ST_CAPTURE;

    function automatic logic [31:0] step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] fold(input logic [OUT_W-1:0] x);
        logic [OUT_CH*32-1:0] pad;
        logic [31:0]          acc;
        pad            = '0;
        pad[OUT_W-1:0] = x;
        acc            = '0;
        for (int k = 0; k < OUT_CH; k++) begin
            acc ^= pad[k*32 +: 32];
        end
        return acc;
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [31:0]     sig_q, sig_d;
    logic [VW-1:0]   idx_q, idx_d;
    logic [IN_W-1:0] in_q, in_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            first;
    logic [1:0]      gen_mode;
    logic [31:0]     gen_seed;
    logic [31:0]     gen_lfsr;
    logic [IN_W-1:0] gen_vec;

    // Next vector generator. On a start edge it works from the live
    // mode/seed inputs, otherwise from the latched run state.
    always_comb begin
        logic [31:0]          s;
        logic [IN_CH*32-1:0]  chunks;
        first    = (state_q == ST_IDLE) || (state_q == ST_DONE);
        gen_mode = first ? mode : mode_q;
        gen_seed = lfsr_q;
        if (first) begin
            gen_seed = (seed == 32'h0) ? 32'h1 : seed;
        end
        s      = gen_seed;
        chunks = '0;
        for (int k = 0; k < IN_CH; k++) begin
            s                  = step(s);
            chunks[k*32 +: 32] = s;
        end
        gen_vec  = '0;
        gen_lfsr = gen_seed;
        unique case (gen_mode)
            2'd0: begin
                gen_vec  = IN_W'(chunks);
                gen_lfsr = s;
            end
            // Walking one as a rotate, avoiding an index modulo IN_W.
            2'd1: begin
                if (first) begin
                    gen_vec = IN_W'(1);
                end else begin
                    gen_vec = (in_q << 1) | (in_q >> (IN_W - 1));
                end
            end
            2'd2: begin
                gen_vec = first ? '0 : ~in_q;
            end
            // Vector 0 is zero and leaves the LFSR at the seed.
            2'd3: begin
                if (!first) begin
                    gen_vec  = IN_W'(chunks);
                    gen_lfsr = s;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        idx_d   = idx_q;
        in_d    = in_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_d  = mode;
                    lfsr_d  = gen_lfsr;
                    sig_d   = SIG_INIT;
                    idx_d   = '0;
                    in_d    = gen_vec;
                    cnt_d   = '0;
                    state_d = ST_APPLY;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CAPTURE: begin
                sig_d = step(sig_q) ^ fold(dut_out);
                if (idx_q == VW'(NUM_VEC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + VW'(1);
                    in_d    = gen_vec;
                    lfsr_d  = gen_lfsr;
                    cnt_d   = '0;
                    state_d = ST_APPLY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            lfsr_q  <= '0;
            sig_q   <= '0;
            idx_q   <= '0;
            in_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            idx_q   <= idx_d;
            in_q    <= in_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);
    assign cap_valid = (state_q == ST_CAPTURE);
    assign dut_in    = in_q;
    assign vec_idx   = idx_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_fuzz_vector_harness.sv
// Bench for fuzz_vector_harness: three instances (small, small with settle,
// full default size) with dut_out looped back from dut_in.
module tb_fuzz_vector_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Instance A: 8/8, 4 vectors, no settle.
    logic        a_start;
    logic [1:0]  a_mode;
    logic [31:0] a_seed;
    logic [7:0]  a_in;
    logic [7:0]  a_out;
    logic        a_busy, a_done, a_cv;
    logic [1:0]  a_idx;
    logic [31:0] a_sig;
    assign a_out = a_in;

    // Instance B: 8/8, 4 vectors, settle 3.
    logic        b_start;
    logic [1:0]  b_mode;
    logic [31:0] b_seed;
    logic [7:0]  b_in;
    logic [7:0]  b_out;
    logic        b_busy, b_done, b_cv;
    logic [1:0]  b_idx;
    logic [31:0] b_sig;
    assign b_out = b_in;

    // Instance C: default sizes.
    logic         c_start;
    logic [1:0]   c_mode;
    logic [31:0]  c_seed;
    logic [255:0] c_in;
    logic [241:0] c_out;
    logic         c_busy, c_done, c_cv;
    logic [4:0]   c_idx;
    logic [31:0]  c_sig;
    assign c_out = c_in[241:0];

    fuzz_vector_harness #(
        .IN_W(8), .OUT_W(8), .NUM_VEC(4), .SETTLE(0)
    ) u_a (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode),
        .seed(a_seed), .dut_in(a_in), .dut_out(a_out),
        .busy(a_busy), .done(a_done), .cap_valid(a_cv),
        .vec_idx(a_idx), .signature(a_sig)
    );

    fuzz_vector_harness #(
        .IN_W(8), .OUT_W(8), .NUM_VEC(4), .SETTLE(3)
    ) u_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode),
        .seed(b_seed), .dut_in(b_in), .dut_out(b_out),
        .busy(b_busy), .done(b_done), .cap_valid(b_cv),
        .vec_idx(b_idx), .signature(b_sig)
    );

    fuzz_vector_harness u_c (
        .clk(clk), .rst(rst), .start(c_start), .mode(c_mode),
        .seed(c_seed), .dut_in(c_in), .dut_out(c_out),
        .busy(c_busy), .done(c_done), .cap_valid(c_cv),
        .vec_idx(c_idx), .signature(c_sig)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_step(input logic [31:0] s);
        return (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0);
    endfunction

    // Vector i computed from scratch: the LFSR has advanced a whole
    // number of vectors' worth of chunks before vector i begins.
    function automatic logic [255:0] m_vec(input int in_w, input int mode,
                                           input logic [31:0] seed,
                                           input int i);
        logic [255:0] v;
        logic [31:0]  s;
        int           ch;
        int           pre;
        v  = '0;
        ch = (in_w + 31) / 32;
        if (mode == 1) begin
            v[i % in_w] = 1'b1;
        end else if (mode == 2) begin
            v = (i % 2 == 1) ? '1 : '0;
        end else if (!(mode == 3 && i == 0)) begin
            s   = (seed == 32'h0) ? 32'h1 : seed;
            pre = (mode == 3) ? (i - 1) * ch : i * ch;
            for (int n = 0; n < pre; n++) s = m_step(s);
            for (int k = 0; k < ch; k++) begin
                s             = m_step(s);
                v[k*32 +: 32] = s;
            end
        end
        for (int b = in_w; b < 256; b++) v[b] = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] m_fold(input logic [255:0] v,
                                           input int out_w);
        logic [255:0] w;
        logic [31:0]  acc;
        w   = v;
        acc = '0;
        for (int b = out_w; b < 256; b++) w[b] = 1'b0;
        for (int k = 0; k < 8; k++) acc ^= w[k*32 +: 32];
        return acc;
    endfunction

    function automatic logic [31:0] m_sig(input int in_w, input int out_w,
                                          input int nvec, input int mode,
                                          input logic [31:0] seed);
        logic [31:0] s;
        s = 32'hFFFFFFFF;
        for (int i = 0; i < nvec; i++) begin
            s = m_step(s) ^ m_fold(m_vec(in_w, mode, seed, i), out_w);
        end
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_go(input logic [1:0] m, input logic [31:0] s);
        @(negedge clk);
        a_mode  = m;
        a_seed  = s;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset_state();
        total++;
        if ({a_in, a_busy, a_done, a_cv, a_idx, a_sig} !== '0) begin
            bad++;
            $display("FAIL rst_a: got in=%h b=%b d=%b cv=%b i=%0d s=%h want 0",
                     a_in, a_busy, a_done, a_cv, a_idx, a_sig);
        end
        total++;
        if ({b_in, b_busy, b_done, b_cv, b_idx, b_sig} !== '0) begin
            bad++;
            $display("FAIL rst_b: got in=%h s=%h want 0", b_in, b_sig);
        end
        total++;
        if ({c_in, c_busy, c_done, c_cv, c_idx, c_sig} !== '0) begin
            bad++;
            $display("FAIL rst_c: got in=%h s=%h want 0", c_in, c_sig);
        end
    endtask

    task automatic test_walking_one();
        logic [31:0] sd;
        logic [31:0] ew;
        logic [7:0]  e;
        sd = $urandom;
        ew = 32'h08040201;
        a_go(2'd1, sd);
        for (int i = 0; i < 4; i++) begin
            e = ew[i*8 +: 8];
            total++;
            if (a_in !== e || a_cv !== 1'b1 || a_idx !== 2'(i)
                || a_done !== 1'b0) begin
                bad++;
                $display("FAIL walk[%0d]: got in=%h cv=%b i=%0d d=%b want in=%h cv=1 i=%0d d=0",
                         i, a_in, a_cv, a_idx, a_done, e, i);
            end
            tick();
            if (i == 0) begin
                total++;
                if (a_sig !== 32'hFB3EE248) begin
                    bad++;
                    $display("FAIL walk_sig0: got %h want FB3EE248", a_sig);
                end
            end
        end
        total++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_cv !== 1'b0) begin
            bad++;
            $display("FAIL walk_done: got d=%b b=%b cv=%b want 1 0 0",
                     a_done, a_busy, a_cv);
        end
        total++;
        if (a_sig !== m_sig(8, 8, 4, 1, sd)) begin
            bad++;
            $display("FAIL walk_sig: got %h want %h", a_sig,
                     m_sig(8, 8, 4, 1, sd));
        end
    endtask

    task automatic test_generators();
        logic [1:0]  tm[8];
        logic [31:0] ts[8];
        logic [31:0] tw[8];
        bit          tk[8];
        logic [255:0] mv;
        logic [31:0]  w;
        tm[0] = 2'd2; ts[0] = $urandom;   tw[0] = 32'hFF00FF00; tk[0] = 1;
        tm[1] = 2'd0; ts[1] = 32'h0;      tw[1] = 32'h10080402; tk[1] = 1;
        tm[2] = 2'd0; ts[2] = 32'h1;      tw[2] = 32'h10080402; tk[2] = 1;
        tm[3] = 2'd3; ts[3] = 32'h1;      tw[3] = 32'h08040200; tk[3] = 1;
        for (int r = 4; r < 8; r++) begin
            tm[r] = 2'($urandom_range(0, 3));
            ts[r] = $urandom;
            tw[r] = '0;
            tk[r] = 0;
        end
        for (int r = 0; r < 8; r++) begin
            a_go(tm[r], ts[r]);
            w = tw[r];
            for (int i = 0; i < 4; i++) begin
                mv = m_vec(8, int'(tm[r]), ts[r], i);
                total++;
                if (a_in !== mv[7:0]) begin
                    bad++;
                    $display("FAIL gen%0d_m%0d[%0d]: got %h want %h",
                             r, tm[r], i, a_in, mv[7:0]);
                end
                if (tk[r]) begin
                    total++;
                    if (a_in !== w[i*8 +: 8]) begin
                        bad++;
                        $display("FAIL gen%0d_const[%0d]: got %h want %h",
                                 r, i, a_in, w[i*8 +: 8]);
                    end
                end
                tick();
            end
            total++;
            if (a_done !== 1'b1
                || a_sig !== m_sig(8, 8, 4, int'(tm[r]), ts[r])) begin
                bad++;
                $display("FAIL gen%0d_sig: got d=%b %h want d=1 %h", r,
                         a_done, a_sig, m_sig(8, 8, 4, int'(tm[r]), ts[r]));
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] sd;
        sd = $urandom;
        a_go(2'd0, sd);
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({a_in, a_busy, a_done, a_cv, a_idx, a_sig} !== '0) begin
            bad++;
            $display("FAIL rst_mid: got in=%h b=%b d=%b cv=%b i=%0d s=%h want 0",
                     a_in, a_busy, a_done, a_cv, a_idx, a_sig);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_sig !== 32'h0) begin
            bad++;
            $display("FAIL rst_idle: got b=%b d=%b s=%h want 0 0 0",
                     a_busy, a_done, a_sig);
        end
        a_go(2'd0, sd);
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (a_done !== 1'b1 || a_sig !== m_sig(8, 8, 4, 0, sd)) begin
            bad++;
            $display("FAIL rst_rerun: got d=%b %h want d=1 %h",
                     a_done, a_sig, m_sig(8, 8, 4, 0, sd));
        end
    endtask

    task automatic test_settle();
        logic [1:0]   m;
        logic [31:0]  sd;
        logic [255:0] mv;
        m  = 2'($urandom_range(0, 3));
        sd = $urandom;
        @(negedge clk);
        b_mode  = m;
        b_seed  = sd;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            mv = m_vec(8, int'(m), sd, c / 4);
            total++;
            if (b_in !== mv[7:0] || b_cv !== (c % 4 == 3)
                || b_idx !== 2'(c / 4) || b_busy !== 1'b1
                || b_done !== 1'b0) begin
                bad++;
                $display("FAIL settle[%0d]: got in=%h cv=%b i=%0d b=%b d=%b want in=%h cv=%b i=%0d b=1 d=0",
                         c, b_in, b_cv, b_idx, b_busy, b_done,
                         mv[7:0], (c % 4 == 3), c / 4);
            end
            tick();
        end
        total++;
        if (b_done !== 1'b1 || b_sig !== m_sig(8, 8, 4, int'(m), sd)) begin
            bad++;
            $display("FAIL settle_done: got d=%b %h want d=1 %h",
                     b_done, b_sig, m_sig(8, 8, 4, int'(m), sd));
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   m;
        logic [31:0]  sd;
        logic [31:0]  es;
        logic [255:0] mv;
        m  = 2'($urandom_range(0, 3));
        sd = $urandom;
        es = m_sig(8, 8, 4, int'(m), sd);
        for (int run = 0; run < 2; run++) begin
            a_go(m, sd);
            total++;
            if (a_sig !== 32'hFFFFFFFF || a_busy !== 1'b1
                || a_done !== 1'b0) begin
                bad++;
                $display("FAIL b2b_init%0d: got s=%h b=%b d=%b want FFFFFFFF 1 0",
                         run, a_sig, a_busy, a_done);
            end
            for (int i = 0; i < 4; i++) begin
                mv = m_vec(8, int'(m), sd, i);
                total++;
                if (a_in !== mv[7:0] || a_idx !== 2'(i)) begin
                    bad++;
                    $display("FAIL b2b%0d[%0d]: got in=%h i=%0d want in=%h i=%0d",
                             run, i, a_in, a_idx, mv[7:0], i);
                end
                @(negedge clk);
                a_start = 1'b1;
                a_mode  = 2'($urandom_range(0, 3));
                a_seed  = $urandom;
                tick();
                a_start = 1'b0;
            end
            for (int h = 0; h < 2; h++) tick();
            total++;
            if (a_done !== 1'b1 || a_sig !== es) begin
                bad++;
                $display("FAIL b2b_sig%0d: got d=%b %h want d=1 %h",
                         run, a_done, a_sig, es);
            end
        end
    endtask

    task automatic test_defaults(input logic [1:0] m, input logic [31:0] sd);
        logic [255:0] mv;
        int           n;
        @(negedge clk);
        c_mode  = m;
        c_seed  = sd;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        n = 0;
        while (!c_done && n < 100) begin
            mv = m_vec(256, int'(m), sd, n);
            total++;
            if (c_in !== mv || c_idx !== 5'(n) || c_cv !== 1'b1) begin
                bad++;
                $display("FAIL dflt_vec[%0d]: got %h i=%0d want %h",
                         n, c_in, c_idx, mv);
            end
            tick();
            n++;
        end
        total++;
        if (c_done !== 1'b1 || n != 21) begin
            bad++;
            $display("FAIL dflt_done: got d=%b after %0d edges want d=1 after 21",
                     c_done, n);
        end
        total++;
        if (c_sig !== m_sig(256, 242, 21, int'(m), sd)) begin
            bad++;
            $display("FAIL dflt_sig: got %h want %h", c_sig,
                     m_sig(256, 242, 21, int'(m), sd));
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_start = 1'b0; a_mode = '0; a_seed = '0;
        b_start = 1'b0; b_mode = '0; b_seed = '0;
        c_start = 1'b0; c_mode = '0; c_seed = '0;
        tick();
        tick();
        test_reset_state();
        @(negedge clk);
        rst = 1'b0;
        tick();
        test_walking_one();
        test_generators();
        test_reset_midrun();
        test_settle();
        test_back_to_back();
        test_defaults(2'd0, 32'hDEADBEEF);
        test_defaults(2'($urandom_range(0, 3)), $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
